// File: rtl/systolic_feed_ctrl.sv
// Purpose : feed sequencer for an N x N systolic array. It loads A/B operand slices into the
//           per-row and per-column input FIFOs, issues diagonally staggered FIFO reads, waits
//           for the PE pipeline to drain, and then pulses done.
// Latency : write enables follow an accepted beat by 1 cycle. After the last load handshake
//           the job takes 1 (arm) + K+N-1 (feed) + 2N (flush) cycles, and done follows.
// Backpr. : in_ready_o is combinational and is high only in LOAD while the selected operand
//           still needs beats. Beats for an exhausted operand are held off.
// Ports   : clk_i/rstn_i clock and async active-low reset; start_i/k_len_i job request;
//           in_valid_i/in_ready_o/in_sel_i/in_data_i operand stream; row_*/col_* FIFO write
//           data, write enables and read enables; busy_o job in flight; done_o completion pulse.
`timescale 1ns/1ps
module systolic_feed_ctrl #(
  parameter int N          = 3,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    start_i,
  input  logic [3:0]              k_len_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic                    in_sel_i,
  input  logic [N*DATA_WIDTH-1:0] in_data_i,
  output logic [N*DATA_WIDTH-1:0] row_wdata_o,
  output logic [N-1:0]            row_w_en_o,
  output logic [N-1:0]            row_r_en_o,
  output logic [N*DATA_WIDTH-1:0] col_wdata_o,
  output logic [N-1:0]            col_w_en_o,
  output logic [N-1:0]            col_r_en_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int KW = $clog2(DEPTH + 1);
  // t_q counts both feed cycles (up to K+N-2) and flush cycles (up to 2N-1)
  localparam int TW = $clog2(DEPTH + 2*N + 1);
  localparam logic [TW-1:0] FLUSH_LAST = TW'(2*N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_FEED,
    S_FLUSH
  } state_t;

  state_t                  state_q;
  logic [KW-1:0]           k_q;
  logic [KW-1:0]           k_clip;
  logic [KW-1:0]           a_cnt_q, a_cnt_d;
  logic [KW-1:0]           b_cnt_q, b_cnt_d;
  logic [TW-1:0]           t_q, t_d;
  logic [TW-1:0]           feed_last;
  logic [TW-1:0]           t_sel;
  logic [N*DATA_WIDTH-1:0] row_wdata_q, col_wdata_q;
  logic [N-1:0]            row_w_en_q, col_w_en_q;
  logic [N-1:0]            r_en_q, r_en_d;
  logic                    busy_q, done_q;
  logic                    a_acc, b_acc;

  // Requested K is clipped to the FIFO depth.
  assign k_clip = (int'(k_len_i) > DEPTH) ? KW'(DEPTH) : KW'(k_len_i);

  always_comb begin
    in_ready_o = 1'b0;
    if (state_q == S_LOAD) begin
      in_ready_o = in_sel_i ? (b_cnt_q < k_q) : (a_cnt_q < k_q);
    end
  end

  // in_sel_i selects a single operand, so A and B can never be accepted together
  assign a_acc   = in_valid_i && in_ready_o && !in_sel_i;
  assign b_acc   = in_valid_i && in_ready_o &&  in_sel_i;
  assign a_cnt_d = a_cnt_q + {{(KW-1){1'b0}}, a_acc};
  assign b_cnt_d = b_cnt_q + {{(KW-1){1'b0}}, b_acc};

  assign t_d       = t_q + TW'(1);
  assign feed_last = TW'(k_q) + TW'(N) - TW'(2);

  // Read enables are registered. They are computed for the feed index of the next cycle:
  // index 0 when leaving ARM, and t_q+1 while feeding.
  always_comb begin
    r_en_d = '0;
    t_sel  = (state_q == S_FEED) ? t_d : '0;
    for (int i = 0; i < N; i++) begin
      r_en_d[i] = (t_sel >= TW'(i)) && (t_sel < TW'(i) + TW'(k_q));
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      a_cnt_q     <= '0;
      b_cnt_q     <= '0;
      t_q         <= '0;
      row_wdata_q <= '0;
      col_wdata_q <= '0;
      row_w_en_q  <= '0;
      col_w_en_q  <= '0;
      r_en_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      row_w_en_q <= '0;
      col_w_en_q <= '0;
      done_q     <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i && (k_len_i != 4'd0)) begin
            k_q     <= k_clip;
            a_cnt_q <= '0;
            b_cnt_q <= '0;
            t_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          a_cnt_q <= a_cnt_d;
          b_cnt_q <= b_cnt_d;
          if (a_acc) begin
            row_wdata_q <= in_data_i;
            row_w_en_q  <= '1;
          end
          if (b_acc) begin
            col_wdata_q <= in_data_i;
            col_w_en_q  <= '1;
          end
          // Look at the post-handshake counts so ARM directly follows the last beat
          if ((a_cnt_d == k_q) && (b_cnt_d == k_q)) begin
            state_q <= S_ARM;
          end
        end
        S_ARM: begin
          t_q     <= '0;
          r_en_q  <= r_en_d;
          state_q <= S_FEED;
        end
        S_FEED: begin
          if (t_q == feed_last) begin
            t_q     <= '0;
            r_en_q  <= '0;
            state_q <= S_FLUSH;
          end else begin
            t_q    <= t_d;
            r_en_q <= r_en_d;
          end
        end
        S_FLUSH: begin
          if (t_q == FLUSH_LAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            t_q <= t_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Rows and columns share K and N, so one stagger register drives both.
  assign row_wdata_o = row_wdata_q;
  assign col_wdata_o = col_wdata_q;
  assign row_w_en_o  = row_w_en_q;
  assign col_w_en_o  = col_w_en_q;
  assign row_r_en_o  = r_en_q;
  assign col_r_en_o  = r_en_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
